// File: rtl/axi_lite_cfg_responder.sv
// AXI4-Lite subordinate exposing NUM_REGS-1 read/write configuration words
// plus one read-only status word at the top index.
module axi_lite_cfg_responder #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 9,
    parameter int unsigned NUM_REGS           = 8
) (
    input  logic                                      S_AXI_ACLK,
    input  logic                                      S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
    input  logic                                      S_AXI_AWVALID,
    output logic                                      S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
    input  logic                                      S_AXI_WVALID,
    output logic                                      S_AXI_WREADY,
    output logic [1:0]                                S_AXI_BRESP,
    output logic                                      S_AXI_BVALID,
    input  logic                                      S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
    input  logic                                      S_AXI_ARVALID,
    output logic                                      S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
    output logic [1:0]                                S_AXI_RRESP,
    output logic                                      S_AXI_RVALID,
    input  logic                                      S_AXI_RREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             status_in,
    output logic [(NUM_REGS-1)*C_S_AXI_DATA_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-2:0]                       cfg_wr_strobe
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NB     = DW / 8;
    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned NUM_RW = NUM_REGS - 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_RESP = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    logic [0:0]    wr_state, wr_next;
    logic [0:0]    rd_state, rd_next;
    logic [DW-1:0] regs [NUM_RW];

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_ok, rd_ok;
    logic [DW-1:0]    rd_word;
    logic             unused_addr_lsbs;

    assign wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_ok  = (wr_idx < IDX_W'(NUM_RW));
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
        assign cfg_regs[g*DW +: DW] = regs[g];
    end

    // Read mux: RW registers, then status, anything above is a decode error.
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b0;
        for (int k = 0; k < NUM_RW; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_word = regs[k];
                rd_ok   = 1'b1;
            end
        end
        if (rd_idx == IDX_W'(NUM_RW)) begin
            rd_word = status_in;
            rd_ok   = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (S_AXI_AWREADY) wr_next = WR_RESP;
            WR_RESP: if (S_AXI_BREADY)  wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (S_AXI_ARREADY) rd_next = RD_DATA;
            RD_DATA: if (S_AXI_RREADY)  rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Write channel: one-cycle READY pulse, commit and BVALID on the following edge.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            cfg_wr_strobe <= '0;
            for (int k = 0; k < NUM_RW; k++) regs[k] <= '0;
        end else begin
            cfg_wr_strobe <= '0;
            if (wr_state == WR_IDLE) begin
                if (S_AXI_AWREADY) begin
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_WREADY  <= 1'b0;
                    S_AXI_BVALID  <= 1'b1;
                    S_AXI_BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    for (int k = 0; k < NUM_RW; k++) begin
                        if (wr_idx == IDX_W'(k)) begin
                            cfg_wr_strobe[k] <= 1'b1;
                            for (int b = 0; b < NB; b++) begin
                                if (S_AXI_WSTRB[b]) regs[k][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                            end
                        end
                    end
                end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    S_AXI_AWREADY <= 1'b1;
                    S_AXI_WREADY  <= 1'b1;
                end
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read channel: data captured at the handshake edge, so a same-edge write is not visible.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else if (rd_state == RD_IDLE) begin
            if (S_AXI_ARREADY) begin
                S_AXI_ARREADY <= 1'b0;
                S_AXI_RVALID  <= 1'b1;
                S_AXI_RDATA   <= rd_word;
                S_AXI_RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_ARVALID) begin
                S_AXI_ARREADY <= 1'b1;
            end
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_cfg_responder.sv
// Directed bench for axi_lite_cfg_responder: reset, read-back, strobes,
// status/decode errors, backpressure and mid-transaction reset.
module tb_axi_lite_cfg_responder;

    localparam int unsigned AW = 9;
    localparam int unsigned NR = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [31:0]     status_in = '0;
    logic [(NR-1)*32-1:0] cfg_regs;
    logic [NR-2:0]   cfg_wr_strobe;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_cfg_responder #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .status_in(status_in),
        .cfg_regs(cfg_regs),
        .cfg_wr_strobe(cfg_wr_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200us");
        $fatal(1);
    end

    task automatic wait_awready();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!awready && n < 20);
        n_cmp++;
        if (awready !== 1'b1) begin
            n_err++;
            $display("FAIL aw_handshake_timeout awready=%b required 1", awready);
        end
    endtask

    task automatic wait_arready();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!arready && n < 20);
        n_cmp++;
        if (arready !== 1'b1) begin
            n_err++;
            $display("FAIL ar_handshake_timeout arready=%b required 1", arready);
        end
    endtask

    // Full write transaction; returns what was seen on the cycle after the READY pulse.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NR-2:0] stb, output logic bv);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_awready();
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        bv = bvalid; resp = bresp; stb = cfg_wr_strobe;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output logic rv);
        araddr = a; arvalid = 1'b1;
        wait_arready();
        @(posedge clk); #1;
        arvalid = 1'b0;
        rv = rvalid; d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; logic v;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || cfg_regs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs hs=%b cfg=%h required all zero",
                     {awready, wready, arready, bvalid, rvalid}, cfg_regs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read(9'h000, d, r, v);
        n_cmp++;
        if ({v, r, d} !== {1'b1, 2'b00, 32'h0}) begin
            n_err++;
            $display("FAIL reset_read0 rv=%b resp=%b data=%h required 1 00 00000000", v, r, d);
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] d; logic [1:0] r; logic [NR-2:0] s; logic v;
        axi_write(9'h000, 32'hDEADBEEF, 4'hF, r, s, v);
        n_cmp++;
        if ({v, r, s} !== {1'b1, 2'b00, 7'b0000001}) begin
            n_err++;
            $display("FAIL wr0_resp bvalid=%b bresp=%b strobe=%b required 1 00 0000001", v, r, s);
        end
        n_cmp++;
        if (cfg_wr_strobe !== 7'b0 || cfg_regs[31:0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr0_after strobe=%b reg0=%h required 0000000 deadbeef",
                     cfg_wr_strobe, cfg_regs[31:0]);
        end
        axi_read(9'h000, d, r, v);
        n_cmp++;
        if ({v, r, d} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL rd0_deadbeef rv=%b resp=%b data=%h required 1 00 deadbeef", v, r, d);
        end
        axi_write(9'h003, 32'h00000006, 4'hF, r, s, v);
        axi_read(9'h000, d, r, v);
        n_cmp++;
        if ({r, d} !== {2'b00, 32'h00000006}) begin
            n_err++;
            $display("FAIL rd0_six resp=%b data=%h required 00 00000006", r, d);
        end
        axi_write(9'h000, 32'hFFFFFFFF, 4'h0, r, s, v);
        axi_read(9'h000, d, r, v);
        n_cmp++;
        if ({s, d} !== {7'b0000001, 32'h00000006}) begin
            n_err++;
            $display("FAIL wr0_nostrb strobe=%b data=%h required 0000001 00000006", s, d);
        end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] d; logic [1:0] r; logic [NR-2:0] s; logic v;
        axi_write(9'h004, 32'hFFFFFFFF, 4'hF, r, s, v);
        axi_write(9'h004, 32'h12345678, 4'b0101, r, s, v);
        n_cmp++;
        if ({r, s} !== {2'b00, 7'b0000010}) begin
            n_err++;
            $display("FAIL wr1_resp bresp=%b strobe=%b required 00 0000010", r, s);
        end
        axi_read(9'h004, d, r, v);
        n_cmp++;
        if (d !== 32'hFF34FF78 || cfg_regs[63:32] !== 32'hFF34FF78) begin
            n_err++;
            $display("FAIL rd1_bytes data=%h reg1=%h required ff34ff78", d, cfg_regs[63:32]);
        end
    endtask

    task automatic test_status_errors();
        logic [31:0] d; logic [1:0] r; logic [NR-2:0] s; logic v;
        status_in = 32'hA5A50001;
        axi_read(9'h01C, d, r, v);
        n_cmp++;
        if ({r, d} !== {2'b00, 32'hA5A50001}) begin
            n_err++;
            $display("FAIL rd_status resp=%b data=%h required 00 a5a50001", r, d);
        end
        axi_write(9'h01C, 32'h0BADF00D, 4'hF, r, s, v);
        n_cmp++;
        if ({v, r, s} !== {1'b1, 2'b10, 7'b0}) begin
            n_err++;
            $display("FAIL wr_status bvalid=%b bresp=%b strobe=%b required 1 10 0000000", v, r, s);
        end
        axi_write(9'h100, 32'h0BADF00D, 4'hF, r, s, v);
        n_cmp++;
        if ({r, s} !== {2'b10, 7'b0}) begin
            n_err++;
            $display("FAIL wr_oor bresp=%b strobe=%b required 10 0000000", r, s);
        end
        axi_read(9'h100, d, r, v);
        n_cmp++;
        if ({r, d} !== {2'b10, 32'h0}) begin
            n_err++;
            $display("FAIL rd_oor resp=%b data=%h required 10 00000000", r, d);
        end
    endtask

    task automatic test_backpressure();
        awaddr = 9'h008; wdata = 32'h00000011; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_awready();
        @(posedge clk); #1;
        // A second write stays presented while the response is stalled.
        wdata = 32'h00000022;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bvalid, bresp, awready, wready} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_write cyc=%0d bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                         i, bvalid, bresp, awready, wready);
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b0 || cfg_regs[95:64] !== 32'h00000011) begin
            n_err++;
            $display("FAIL bp_write_done bvalid=%b reg2=%h required 0 00000011", bvalid, cfg_regs[95:64]);
        end
        araddr = 9'h008; arvalid = 1'b1;
        wait_arready();
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h00000011}) begin
                n_err++;
                $display("FAIL bp_read cyc=%0d rvalid=%b rresp=%b rdata=%h required 1 00 00000011",
                         i, rvalid, rresp, rdata);
            end
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_read_done rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d; logic [1:0] r; logic [NR-2:0] s; logic v;
        awaddr = 9'h00C; wdata = 32'h33333333; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_awready();
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre bvalid=%b required 1", bvalid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bvalid !== 1'b0 || cfg_regs !== '0 || cfg_wr_strobe !== '0) begin
            n_err++;
            $display("FAIL midrst_clear bvalid=%b strobe=%b cfg=%h required 0 0 0",
                     bvalid, cfg_wr_strobe, cfg_regs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_noresp bvalid=%b required 0", bvalid);
        end
        axi_write(9'h000, 32'hCAFEF00D, 4'hF, r, s, v);
        n_cmp++;
        if ({v, r, s} !== {1'b1, 2'b00, 7'b0000001}) begin
            n_err++;
            $display("FAIL midrst_wr bvalid=%b bresp=%b strobe=%b required 1 00 0000001", v, r, s);
        end
        axi_read(9'h000, d, r, v);
        n_cmp++;
        if ({r, d} !== {2'b00, 32'hCAFEF00D}) begin
            n_err++;
            $display("FAIL midrst_rd resp=%b data=%h required 00 cafef00d", r, d);
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_byte_strobes();
        test_status_errors();
        test_backpressure();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
